// File: rtl/axis_switch_nto1_rr_pkg.sv
// Shared types and helpers for the N-to-1 round-robin AXI4-Stream switch.
package axis_switch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int MAX_PORTS = 16;
    localparam int PTR_W     = 4;

    // Searches upward from ptr+1, wrapping at n, and returns the first requester one-hot.
    function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                     input logic [PTR_W-1:0]     ptr,
                                                     input int                   n);
        logic [MAX_PORTS-1:0] win;
        logic                 found;
        int                   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            if (i <= n && !found) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx]) begin
                    win[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return win;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [MAX_PORTS-1:0] oh);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) r = PTR_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_switch_nto1_rr_if.sv
// Generic valid/ready stream carrying one packed payload word.
interface axis_switch_nto1_rr_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/axis_switch_nto1_rr_skid2.sv
// Two-entry skid buffer; upstream ready comes only from a registered full flag.
module axis_skid2 #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_switch_nto1_rr_if.slave  in_s,
    axis_switch_nto1_rr_if.master out_m
);

    logic [W-1:0] mem [2];
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         rd_ptr;
    logic         wr_ptr;
    logic         full;
    logic         wr_en;
    logic         rd_en;

    assign in_s.ready  = ~full;
    assign wr_en       = in_s.valid & ~full;
    assign out_m.valid = (count != 2'd0);
    assign rd_en       = out_m.valid & out_m.ready;
    assign out_m.data  = out_m.valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            full   <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count <= count_next;
            full  <= (count_next == 2'd2);
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (rd_en) rd_ptr <= ~rd_ptr;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_s.data;
    end

endmodule

// File: rtl/axis_switch_nto1_rr.sv
// N-to-1 AXI4-Stream switch with packet-atomic round-robin arbitration and a skid output.
module axis_switch_nto1_rr
    import axis_switch_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int TDATA_L = 512,
    parameter int TUSER_L = 81,
    parameter int TKEEP_L = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PORTS-1:0]           s_req_supress,
    input  logic [N_PORTS*TDATA_L-1:0]   axi_s_tdata_i,
    input  logic [N_PORTS*TUSER_L-1:0]   axi_s_tuser_i,
    input  logic [N_PORTS*TKEEP_L-1:0]   axi_s_tkeep_i,
    input  logic [N_PORTS-1:0]           axi_s_tlast_i,
    input  logic [N_PORTS-1:0]           axi_s_tvalid_i,
    output logic [N_PORTS-1:0]           axi_s_tready_o,
    output logic [TDATA_L-1:0]           axi_m0_tdata_o,
    output logic [TUSER_L-1:0]           axi_m0_tuser_o,
    output logic [TKEEP_L-1:0]           axi_m0_tkeep_o,
    output logic                         axi_m0_tlast_o,
    output logic                         axi_m0_tvalid_o,
    input  logic                         axi_m0_tready_i,
    output logic [N_PORTS-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int PAY_W = TDATA_L + TUSER_L + TKEEP_L + 1;

    state_t               state;
    state_t               state_next;
    logic [N_PORTS-1:0]   grant;
    logic [N_PORTS-1:0]   grant_next;
    logic [N_PORTS-1:0]   cand;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [MAX_PORTS-1:0] pick;
    logic [PAY_W-1:0]     sel_payload;
    logic                 sel_valid;
    logic                 in_hs;

    axis_switch_nto1_rr_if #(.W(PAY_W)) sw_in  ();
    axis_switch_nto1_rr_if #(.W(PAY_W)) sw_out ();

    assign cand = axi_s_tvalid_i & ~s_req_supress;
    assign pick = rr_pick(MAX_PORTS'(cand), ptr, N_PORTS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= PTR_W'(N_PORTS - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (|cand) begin
                    grant_next = pick[N_PORTS-1:0];
                    ptr_next   = onehot_idx(pick);
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (in_hs && sel_payload[0]) begin
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload order {tdata, tuser, tkeep, tlast}; the grant is one-hot so at most one port matches.
    always_comb begin
        axi_s_tready_o = '0;
        sel_payload    = '0;
        sel_valid      = 1'b0;
        if (state == LOCK) begin
            axi_s_tready_o = grant & {N_PORTS{sw_in.ready}};
            for (int i = 0; i < N_PORTS; i++) begin
                if (grant[i]) begin
                    sel_payload = {axi_s_tdata_i[i*TDATA_L +: TDATA_L],
                                   axi_s_tuser_i[i*TUSER_L +: TUSER_L],
                                   axi_s_tkeep_i[i*TKEEP_L +: TKEEP_L],
                                   axi_s_tlast_i[i]};
                    sel_valid   = axi_s_tvalid_i[i];
                end
            end
        end
    end

    assign sw_in.data  = sel_payload;
    assign sw_in.valid = sel_valid;
    assign in_hs       = sel_valid & sw_in.ready;

    axis_skid2 #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .in_s  (sw_in.slave),
        .out_m (sw_out.master)
    );

    assign {axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tkeep_o, axi_m0_tlast_o} = sw_out.data;
    assign axi_m0_tvalid_o = sw_out.valid;
    assign sw_out.ready    = axi_m0_tready_i;

    assign grant_o = grant;
    assign busy_o  = (state == LOCK);

endmodule

// File: tb/tb_axis_switch_nto1_rr.sv
// Self-checking bench: per-port packet queues, a scoreboard of accepted beats and a table of arbitration scenarios.
module tb_axis_switch_nto1_rr;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int UW = 81;
    localparam int KW = 16;
    localparam int PW = DW + UW + KW + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] supr;
        int           npkt;
        int           plen;
        int           exp_n;
        logic [31:0]  exp_order;
        int           gap;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      supr;
    logic [N*DW-1:0]   s_data;
    logic [N*UW-1:0]   s_user;
    logic [N*KW-1:0]   s_keep;
    logic [N-1:0]      s_last;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [DW-1:0]     m_tdata;
    logic [UW-1:0]     m_tuser;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_ready;
    logic [N-1:0]      grant;
    logic              busy;

    beat_t       inq [N][$];
    beat_t       sb[$];
    int          obs_order[$];
    int          obs_cycle[$];
    logic [N-1:0] hs;
    int          occ;
    int          cyc;
    int          out_beats;
    int          passed;
    int          total;
    logic        in_pkt;
    logic [7:0]  cur_tag;
    logic        prev_valid;
    logic        prev_ready;
    logic [PW-1:0] prev_data;
    vec_t        vecs [6];

    axis_switch_nto1_rr_if #(.W(PW)) mon ();
    assign mon.data  = {m_tdata, m_tuser, m_tkeep, m_tlast};
    assign mon.valid = m_tvalid;
    assign mon.ready = m_ready;

    axis_switch_nto1_rr #(
        .N_PORTS (N),
        .TDATA_L (DW),
        .TUSER_L (UW),
        .TKEEP_L (KW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_req_supress   (supr),
        .axi_s_tdata_i   (s_data),
        .axi_s_tuser_i   (s_user),
        .axi_s_tkeep_i   (s_keep),
        .axi_s_tlast_i   (s_last),
        .axi_s_tvalid_i  (s_valid),
        .axi_s_tready_o  (s_ready),
        .axi_m0_tdata_o  (m_tdata),
        .axi_m0_tuser_o  (m_tuser),
        .axi_m0_tkeep_o  (m_tkeep),
        .axi_m0_tlast_o  (m_tlast),
        .axi_m0_tvalid_o (m_tvalid),
        .axi_m0_tready_i (m_ready),
        .grant_o         (grant),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] want);
        total++;
        if (act === want) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    // Tag {src, beat index} lives in tuser[7:0] so tdata stays free for test patterns.
    function automatic beat_t mk_beat(input int src, input int idx, input logic last);
        beat_t       b;
        logic [95:0] u;
        for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
        u = {$urandom(), $urandom(), $urandom()};
        b.user      = u[UW-1:0];
        b.user[7:0] = {src[3:0], idx[3:0]};
        b.keep      = KW'($urandom());
        b.last      = last;
        return b;
    endfunction

    task automatic push_pkt(input int src, input int len);
        for (int j = 0; j < len; j++) inq[src].push_back(mk_beat(src, j, (j == len - 1)));
    endtask

    task automatic refresh();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (inq[i].size() > 0) begin
                b = inq[i][0];
                s_valid[i]           = 1'b1;
                s_data[i*DW +: DW]   = b.data;
                s_user[i*UW +: UW]   = b.user;
                s_keep[i*KW +: KW]   = b.keep;
                s_last[i]            = b.last;
            end else begin
                s_valid[i]           = 1'b0;
                s_data[i*DW +: DW]   = '0;
                s_user[i*UW +: UW]   = '0;
                s_keep[i*KW +: KW]   = '0;
                s_last[i]            = 1'b0;
            end
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) inq[i].delete();
        sb.delete();
        obs_order.delete();
        obs_cycle.delete();
        occ        = 0;
        out_beats  = 0;
        in_pkt     = 1'b0;
        prev_valid = 1'b0;
        hs         = '0;
        refresh();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        supr    = '0;
        m_ready = 1'b1;
        clear_bench();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_bench();
    endtask

    task automatic wait_pkts(input int n, input int budget);
        int c;
        c = 0;
        while (obs_order.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait_pkts", obs_order.size() >= n, 1);
    endtask

    function automatic int order_at(input int k);
        return (obs_order.size() > k) ? obs_order[k] : 99;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        do_reset();
        supr = v.supr;
        for (int p = 0; p < v.npkt; p++)
            for (int i = 0; i < N; i++)
                if (v.mask[i]) push_pkt(i, v.plen);
        refresh();
    endtask

    task automatic check_output(input vec_t v);
        wait_pkts(v.exp_n, 200);
        repeat (6) @(negedge clk);
        check("pkt_count", obs_order.size(), v.exp_n);
        for (int k = 0; k < v.exp_n; k++) begin
            check("rr_order", order_at(k), v.exp_order[k*4 +: 4]);
            if (v.gap != 0 && k > 0 && k < obs_cycle.size())
                check("pkt_gap", obs_cycle[k] - obs_cycle[k-1], v.gap);
        end
        check("sb_drained", sb.size(), 0);
    endtask

    // Driver: retire heads that handshook at the last edge, then present the next beats.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++)
                if (hs[i] && inq[i].size() > 0) void'(inq[i].pop_front());
            hs = '0;
            #1;
            refresh();
        end
    end

    // Monitor: scoreboard compare, packet contiguity, stall stability and skid occupancy.
    initial begin
        beat_t      want;
        logic [7:0] tag;
        forever begin
            @(negedge clk);
            cyc++;
            if (|s_ready) check("ready_not_full", occ < 2, 1);
            if (prev_valid && !prev_ready) begin
                check("stall_valid", mon.valid, 1);
                check("stall_data", mon.data, prev_data);
            end
            prev_valid = mon.valid;
            prev_ready = mon.ready;
            prev_data  = mon.data;
            if (mon.valid && mon.ready) begin
                check("sb_has_beat", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    want = sb.pop_front();
                    check("payload", mon.data, want);
                end
                tag = mon.data[KW+1 +: 8];
                if (in_pkt) begin
                    check("contiguous", tag, {cur_tag[7:4], cur_tag[3:0] + 4'd1});
                end else begin
                    check("first_beat", tag[3:0], 0);
                    obs_order.push_back(int'(tag[7:4]));
                    obs_cycle.push_back(cyc);
                end
                cur_tag = tag;
                in_pkt  = ~mon.data[0];
                out_beats++;
                occ--;
            end
            for (int i = 0; i < N; i++) begin
                hs[i] = s_valid[i] & s_ready[i];
                if (hs[i]) begin
                    sb.push_back(inq[i][0]);
                    occ++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        beat_t      b;
        int         c;
        logic       found;
        logic [5:0] pat;

        passed = 0;
        total  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        supr   = '0;
        m_ready = 1'b1;
        s_valid = '0;
        s_data  = '0;
        s_user  = '0;
        s_keep  = '0;
        s_last  = '0;

        vecs[0] = '{4'b1111, 4'b0000, 1, 1, 4, 32'h0000_3210, 2};
        vecs[1] = '{4'b1010, 4'b0000, 1, 2, 2, 32'h0000_0031, 0};
        vecs[2] = '{4'b1001, 4'b0000, 2, 1, 4, 32'h0000_3030, 2};
        vecs[3] = '{4'b1111, 4'b0000, 2, 1, 8, 32'h3210_3210, 2};
        vecs[4] = '{4'b0110, 4'b0100, 1, 3, 1, 32'h0000_0001, 0};
        vecs[5] = '{4'b1100, 4'b0000, 1, 1, 2, 32'h0000_0032, 2};

        do_reset();
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_sready", s_ready, 0);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_mdata", mon.data, 0);

        $display("[TB] single-beat latency");
        do_reset();
        b = mk_beat(0, 0, 1'b1);
        b.data      = '0;
        b.data[7:0] = 8'hA5;
        inq[0].push_back(b);
        refresh();
        @(negedge clk);
        check("lat_t_sready", s_ready, 0);
        check("lat_t_busy", busy, 0);
        @(negedge clk);
        check("lat_t1_sready", s_ready, 4'b0001);
        check("lat_t1_grant", grant, 4'b0001);
        check("lat_t1_busy", busy, 1);
        check("lat_t1_mvalid", m_tvalid, 0);
        @(negedge clk);
        check("lat_t2_mvalid", m_tvalid, 1);
        check("lat_t2_mdata", m_tdata, 8'hA5);
        check("lat_t2_mlast", m_tlast, 1);
        check("lat_t2_grant", grant, 0);
        repeat (3) @(negedge clk);

        $display("[TB] arbitration table");
        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v]);
            check_output(vecs[v]);
        end

        $display("[TB] packet atomicity");
        do_reset();
        push_pkt(1, 3);
        refresh();
        repeat (2) @(posedge clk);
        #2;
        push_pkt(0, 1);
        refresh();
        wait_pkts(2, 100);
        repeat (4) @(negedge clk);
        check("atom_first", order_at(0), 1);
        check("atom_second", order_at(1), 0);
        check("atom_beats", out_beats, 4);
        check("atom_sb", sb.size(), 0);

        $display("[TB] suppression");
        do_reset();
        supr = 4'b0001;
        push_pkt(0, 1);
        push_pkt(1, 3);
        refresh();
        c = 0;
        while (grant != 4'b0010 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("supr_grant_s1", grant, 4'b0010);
        #1;
        supr = 4'b0010;
        wait_pkts(2, 100);
        repeat (4) @(negedge clk);
        check("supr_first", order_at(0), 1);
        check("supr_second", order_at(1), 0);
        check("supr_beats", out_beats, 4);

        $display("[TB] backpressure");
        do_reset();
        pat = 6'b100101;
        push_pkt(2, 4);
        refresh();
        c = 0;
        while (!m_tvalid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("bp_valid_seen", m_tvalid, 1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            m_ready = pat[k];
        end
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        wait_pkts(1, 100);
        repeat (8) @(negedge clk);
        check("bp_beats", out_beats, 4);
        check("bp_sb", sb.size(), 0);

        $display("[TB] reset mid-packet");
        do_reset();
        push_pkt(0, 4);
        refresh();
        c = 0;
        found = 1'b0;
        while (!found && c < 30) begin
            @(negedge clk);
            c++;
            if (s_valid[0] && s_ready[0] && s_user[3:0] == 4'd1) found = 1'b1;
        end
        check("rst_beat2_seen", found, 1);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_bench();
        @(negedge clk);
        check("mrst_sready", s_ready, 0);
        check("mrst_mvalid", m_tvalid, 0);
        check("mrst_grant", grant, 0);
        check("mrst_busy", busy, 0);
        check("mrst_mdata", mon.data, 0);
        @(posedge clk);
        #2;
        push_pkt(0, 1);
        push_pkt(3, 1);
        refresh();
        wait_pkts(2, 50);
        check("mrst_first", order_at(0), 0);
        check("mrst_second", order_at(1), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
